// File: rtl/lock_controller_if.sv
// Keypad / code-store side signals of the lock controller.
// The controller sits on the slave modport; the keypad/code store drives the master side.
interface lock_controller_if;
  logic       enter_i;
  logic [2:0] compare_i;
  logic       prog_req_i;
  logic [1:0] code_no_o;
  logic       program_o;
  logic       unlock_o;
  logic       alarm_o;

  modport master (
    output enter_i, compare_i, prog_req_i,
    input  code_no_o, program_o, unlock_o, alarm_o
  );

  modport slave (
    input  enter_i, compare_i, prog_req_i,
    output code_no_o, program_o, unlock_o, alarm_o
  );
endinterface

// File: rtl/lock_controller.sv
// Three-code keypad lock: checks codes against the store, opens for a fixed time,
// lets the user reprogram the codes while open, and locks out after repeated failures.
module lock_controller #(
  parameter int unsigned OPEN_CYCLES = 100,
  parameter int unsigned LOCK_CYCLES = 200,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  lock_controller_if.slave bus_io
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned FAIL_W  = 2;
  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_CHK0    = 4'd0;
  localparam logic [STATE_W-1:0] S_CHK1    = 4'd1;
  localparam logic [STATE_W-1:0] S_CHK2    = 4'd2;
  localparam logic [STATE_W-1:0] S_OPEN    = 4'd3;
  localparam logic [STATE_W-1:0] S_PROG0   = 4'd4;
  localparam logic [STATE_W-1:0] S_PROG1   = 4'd5;
  localparam logic [STATE_W-1:0] S_PROG2   = 4'd6;
  localparam logic [STATE_W-1:0] S_WR0     = 4'd7;
  localparam logic [STATE_W-1:0] S_WR1     = 4'd8;
  localparam logic [STATE_W-1:0] S_WR2     = 4'd9;
  localparam logic [STATE_W-1:0] S_LOCKOUT = 4'd10;

  localparam logic [TIMER_W-1:0] OPEN_LOAD      = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD      = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT     = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W:0]    FAIL_LIMIT_EXT = (FAIL_W + 1)'(MAX_FAIL);

  logic [STATE_W-1:0] state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               enter_q;

  logic [1:0] code_no_q, code_no_d;
  logic       program_q, program_d;
  logic       unlock_q, unlock_d;
  logic       alarm_q, alarm_d;

  logic            event_c;
  logic            cmp_hit_c;
  logic            timer_zero_c;
  logic [FAIL_W:0] fail_inc_c;

  // An entry event is the rising edge of the enter level.
  assign event_c      = bus_io.enter_i & ~enter_q;
  assign timer_zero_c = (timer_q == '0);
  assign fail_inc_c   = {1'b0, fail_q} + (FAIL_W + 1)'(1);

  // Match flag for the slot checked by the current CHK state.
  always_comb begin
    cmp_hit_c = 1'b0;
    case (state_q)
      S_CHK0:  cmp_hit_c = bus_io.compare_i[0];
      S_CHK1:  cmp_hit_c = bus_io.compare_i[1];
      S_CHK2:  cmp_hit_c = bus_io.compare_i[2];
      default: cmp_hit_c = 1'b0;
    endcase
  end

  // Next state, timer and fail counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    case (state_q)
      S_CHK0, S_CHK1, S_CHK2: begin
        if (event_c) begin
          if (cmp_hit_c) begin
            case (state_q)
              S_CHK0:  state_d = S_CHK1;
              S_CHK1:  state_d = S_CHK2;
              default: begin
                state_d = S_OPEN;
                timer_d = OPEN_LOAD;
                fail_d  = '0;
              end
            endcase
          end else if (fail_inc_c >= FAIL_LIMIT_EXT) begin
            state_d = S_LOCKOUT;
            timer_d = LOCK_LOAD;
            fail_d  = FAIL_LIMIT;
          end else begin
            state_d = S_CHK0;
            fail_d  = fail_inc_c[FAIL_W-1:0];
          end
        end
      end
      S_OPEN: begin
        // Expiry takes priority over a programming request in the same cycle.
        if (timer_zero_c) begin
          state_d = S_CHK0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
          if (event_c && bus_io.prog_req_i) begin
            state_d = S_PROG0;
          end
        end
      end
      S_PROG0: if (event_c) state_d = S_WR0;
      S_PROG1: if (event_c) state_d = S_WR1;
      S_PROG2: if (event_c) state_d = S_WR2;
      S_WR0:   state_d = S_PROG1;
      S_WR1:   state_d = S_PROG2;
      S_WR2:   state_d = S_CHK0;
      S_LOCKOUT: begin
        if (timer_zero_c) begin
          state_d = S_CHK0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = S_CHK0;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    code_no_d = 2'd0;
    program_d = 1'b0;
    unlock_d  = 1'b0;
    alarm_d   = 1'b0;
    case (state_d)
      S_CHK1, S_PROG1: code_no_d = 2'd1;
      S_CHK2, S_PROG2: code_no_d = 2'd2;
      S_WR0: begin
        code_no_d = 2'd0;
        program_d = 1'b1;
      end
      S_WR1: begin
        code_no_d = 2'd1;
        program_d = 1'b1;
      end
      S_WR2: begin
        code_no_d = 2'd2;
        program_d = 1'b1;
      end
      S_OPEN:    unlock_d = 1'b1;
      S_LOCKOUT: alarm_d  = 1'b1;
      default:   code_no_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CHK0;
      timer_q   <= '0;
      fail_q    <= '0;
      enter_q   <= 1'b0;
      code_no_q <= 2'd0;
      program_q <= 1'b0;
      unlock_q  <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      enter_q   <= bus_io.enter_i;
      code_no_q <= code_no_d;
      program_q <= program_d;
      unlock_q  <= unlock_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus_io.code_no_o = code_no_q;
  assign bus_io.program_o = program_q;
  assign bus_io.unlock_o  = unlock_q;
  assign bus_io.alarm_o   = alarm_q;

endmodule
